// File: rtl/rom_loader_pkg.sv
// Shared types and defaults for the ROM-to-memory loader.
package rom_loader_pkg;

   localparam int unsigned MAX_BYTES_DEFAULT = 65536;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WRITE,
      ST_DONE,
      ST_ERROR
   } state_t;

endpackage

// File: rtl/rom_loader.sv
// Copies a combinational ROM byte-by-byte into a destination memory.
// Optional ROM_LOADER_CHECKSUM_EN adds an 8-bit running sum of written bytes.
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int unsigned MAX_BYTES    = MAX_BYTES_DEFAULT,
   parameter logic [31:0] BASE_ADDRESS = 32'd0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic [31:0] rom_address,
   input  logic [7:0]  rom_byte,
   input  logic        rom_done,
   output logic [31:0] mem_address,
   output logic [7:0]  mem_data,
   output logic        mem_write,
   input  logic        mem_ready,
   output logic        busy,
   output logic        load_done,
   output logic        error,
`ifdef ROM_LOADER_CHECKSUM_EN
   output logic [7:0]  checksum,
`endif
   output state_t      dbg_state_o
);

   localparam logic [31:0] LAST_INDEX = 32'(MAX_BYTES - 1);

   state_t      state_q, state_d;
   logic [31:0] count_q, count_d;
   logic [7:0]  data_q,  data_d;
   logic        last_q,  last_d;
`ifdef ROM_LOADER_CHECKSUM_EN
   logic [7:0]  sum_q,   sum_d;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         data_q  <= data_d;
         last_q  <= last_d;
`ifdef ROM_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   // Write handshake: mem_write is the valid; a byte is consumed on the rising
   // edge where mem_write and mem_ready are both high. Until then address, data
   // and the last flag are held in registers and cannot change.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      data_d  = data_q;
      last_d  = last_q;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               count_d = '0;
`ifdef ROM_LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            data_d  = rom_byte;
            last_d  = rom_done;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (mem_ready) begin
`ifdef ROM_LOADER_CHECKSUM_EN
               sum_d = sum_q + data_q;
`endif
               if (last_q) begin
                  state_d = ST_DONE;
               end else if (count_q == LAST_INDEX) begin
                  state_d = ST_ERROR;
               end else begin
                  count_d = count_q + 32'd1;
                  state_d = ST_FETCH;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign rom_address = count_q;
   assign mem_address = BASE_ADDRESS + count_q;
   assign mem_data    = data_q;
   assign mem_write   = (state_q == ST_WRITE);
   assign busy        = (state_q == ST_FETCH) || (state_q == ST_WRITE);
   assign load_done   = (state_q == ST_DONE);
   assign error       = (state_q == ST_ERROR);
   assign dbg_state_o = state_q;
`ifdef ROM_LOADER_CHECKSUM_EN
   assign checksum    = sum_q;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: default, MAX_BYTES=16 and BASE_ADDRESS=0x100 instances.
// Checksum checks are active when ROM_LOADER_CHECKSUM_EN is defined.
module tb_rom_loader;
   import rom_loader_pkg::*;

   int checks   = 0;
   int failures = 0;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  img [0:63];
   logic [39:0] exp_q_a [$];
   logic [39:0] exp_q_m [$];
   logic [39:0] exp_q_b [$];

   // default instance
   logic a_start = 1'b0, a_mem_ready = 1'b1;
   logic [31:0] a_rom_address, a_mem_address;
   logic [7:0]  a_rom_byte, a_mem_data;
   logic a_rom_done, a_mem_write, a_busy, a_load_done, a_error;
   state_t a_state;
   // MAX_BYTES=16 instance
   logic m_start = 1'b0, m_mem_ready = 1'b1;
   logic [31:0] m_rom_address, m_mem_address;
   logic [7:0]  m_rom_byte, m_mem_data;
   logic m_rom_done, m_mem_write, m_busy, m_load_done, m_error;
   state_t m_state;
   // BASE_ADDRESS=0x100 instance
   logic b_start = 1'b0, b_mem_ready = 1'b1;
   logic [31:0] b_rom_address, b_mem_address;
   logic [7:0]  b_rom_byte, b_mem_data;
   logic b_rom_done, b_mem_write, b_busy, b_load_done, b_error;
   state_t b_state;
`ifdef ROM_LOADER_CHECKSUM_EN
   logic [7:0] a_checksum, m_checksum, b_checksum;
`endif

   assign a_rom_byte = (a_rom_address < 32'd54) ? img[a_rom_address[5:0]] : 8'h00;
   assign a_rom_done = (a_rom_address == 32'd53);
   assign m_rom_byte = m_rom_address[7:0] ^ 8'h5A;
   assign m_rom_done = 1'b0;
   assign b_rom_byte = (b_rom_address == 32'd0) ? 8'hA5 : 8'h00;
   assign b_rom_done = (b_rom_address == 32'd0);

   rom_loader u_dut (
      .clk(clk), .reset_n(reset_n), .start(a_start),
      .rom_address(a_rom_address), .rom_byte(a_rom_byte), .rom_done(a_rom_done),
      .mem_address(a_mem_address), .mem_data(a_mem_data), .mem_write(a_mem_write),
      .mem_ready(a_mem_ready), .busy(a_busy), .load_done(a_load_done), .error(a_error),
`ifdef ROM_LOADER_CHECKSUM_EN
      .checksum(a_checksum),
`endif
      .dbg_state_o(a_state)
   );

   rom_loader #(.MAX_BYTES(16)) u_max (
      .clk(clk), .reset_n(reset_n), .start(m_start),
      .rom_address(m_rom_address), .rom_byte(m_rom_byte), .rom_done(m_rom_done),
      .mem_address(m_mem_address), .mem_data(m_mem_data), .mem_write(m_mem_write),
      .mem_ready(m_mem_ready), .busy(m_busy), .load_done(m_load_done), .error(m_error),
`ifdef ROM_LOADER_CHECKSUM_EN
      .checksum(m_checksum),
`endif
      .dbg_state_o(m_state)
   );

   rom_loader #(.BASE_ADDRESS(32'h100)) u_base (
      .clk(clk), .reset_n(reset_n), .start(b_start),
      .rom_address(b_rom_address), .rom_byte(b_rom_byte), .rom_done(b_rom_done),
      .mem_address(b_mem_address), .mem_data(b_mem_data), .mem_write(b_mem_write),
      .mem_ready(b_mem_ready), .busy(b_busy), .load_done(b_load_done), .error(b_error),
`ifdef ROM_LOADER_CHECKSUM_EN
      .checksum(b_checksum),
`endif
      .dbg_state_o(b_state)
   );

   // Scoreboard: every accepted write must match the head of its expected queue.
   always @(negedge clk) begin : monitor
      logic [39:0] e;
      if (a_mem_write && a_mem_ready) begin
         checks++;
         if (exp_q_a.size() == 0) begin
            failures++;
            $display("FAIL write_a unexpected addr=%h data=%h", a_mem_address, a_mem_data);
         end else begin
            e = exp_q_a.pop_front();
            if ({a_mem_address, a_mem_data} !== e) begin
               failures++;
               $display("FAIL write_a got addr=%h data=%h expected addr=%h data=%h",
                        a_mem_address, a_mem_data, e[39:8], e[7:0]);
            end
         end
      end
      if (m_mem_write && m_mem_ready) begin
         checks++;
         if (exp_q_m.size() == 0) begin
            failures++;
            $display("FAIL write_m unexpected addr=%h data=%h", m_mem_address, m_mem_data);
         end else begin
            e = exp_q_m.pop_front();
            if ({m_mem_address, m_mem_data} !== e) begin
               failures++;
               $display("FAIL write_m got addr=%h data=%h expected addr=%h data=%h",
                        m_mem_address, m_mem_data, e[39:8], e[7:0]);
            end
         end
      end
      if (b_mem_write && b_mem_ready) begin
         checks++;
         if (exp_q_b.size() == 0) begin
            failures++;
            $display("FAIL write_b unexpected addr=%h data=%h", b_mem_address, b_mem_data);
         end else begin
            e = exp_q_b.pop_front();
            if ({b_mem_address, b_mem_data} !== e) begin
               failures++;
               $display("FAIL write_b got addr=%h data=%h expected addr=%h data=%h",
                        b_mem_address, b_mem_data, e[39:8], e[7:0]);
            end
         end
      end
   end

   function automatic logic done_flag(input int inst);
      case (inst)
         0:       return a_load_done;
         1:       return m_error;
         default: return b_load_done;
      endcase
   endfunction

   function automatic int q_size(input int inst);
      case (inst)
         0:       return exp_q_a.size();
         1:       return exp_q_m.size();
         default: return exp_q_b.size();
      endcase
   endfunction

`ifdef ROM_LOADER_CHECKSUM_EN
   function automatic logic [7:0] csum_of(input int inst);
      case (inst)
         0:       return a_checksum;
         1:       return m_checksum;
         default: return b_checksum;
      endcase
   endfunction

   function automatic logic [7:0] q_sum(input int inst);
      logic [7:0] s = 8'h00;
      for (int i = 0; i < q_size(inst); i++) begin
         case (inst)
            0:       s = s + exp_q_a[i][7:0];
            1:       s = s + exp_q_m[i][7:0];
            default: s = s + exp_q_b[i][7:0];
         endcase
      end
      return s;
   endfunction
`endif

   task automatic drive_start(input int inst, input logic v);
      case (inst)
         0:       a_start = v;
         1:       m_start = v;
         default: b_start = v;
      endcase
   endtask

   task automatic push_image();
      for (int i = 0; i < 54; i++) exp_q_a.push_back({32'(i), img[i]});
   endtask

   // Pulses start (edge = cycle 0) and waits for the completion flag.
   task automatic run_load(input int inst, input bit stall, input bit poke,
                           input int exp_cycle, input string name);
      int          c;
      int          wait_cnt = 0;
      bit          seen = 1'b0;
      logic [31:0] held_addr = '0;
      logic [7:0]  held_data = '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      logic [7:0]  exp_sum = q_sum(inst);
`endif
      a_mem_ready = stall ? 1'b0 : 1'b1;
      drive_start(inst, 1'b1);
      @(posedge clk); #1;
      drive_start(inst, 1'b0);
`ifdef ROM_LOADER_CHECKSUM_EN
      checks++;
      if (csum_of(inst) !== 8'h00) begin
         failures++;
         $display("FAIL %s csum_clear got=%h expected=00", name, csum_of(inst));
      end
`endif
      for (c = 1; c <= exp_cycle + 40; c++) begin
         @(posedge clk); #1;
         if (poke) drive_start(inst, (c >= 1 && c <= 4));
         if (stall) begin
            if (a_mem_write) begin
               if (wait_cnt == 0) begin
                  held_addr = a_mem_address;
                  held_data = a_mem_data;
               end else begin
                  checks++;
                  if ({a_mem_address, a_mem_data} !== {held_addr, held_data}) begin
                     failures++;
                     $display("FAIL %s stable got=%h/%h expected=%h/%h", name,
                              a_mem_address, a_mem_data, held_addr, held_data);
                  end
               end
               a_mem_ready = (wait_cnt == 3);
               wait_cnt    = (wait_cnt == 3) ? 0 : wait_cnt + 1;
            end else begin
               a_mem_ready = 1'b0;
            end
         end
         if (done_flag(inst)) begin
            seen = 1'b1;
            break;
         end
      end
      drive_start(inst, 1'b0);
      a_mem_ready = 1'b1;
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s timeout expected completion at cycle %0d", name, exp_cycle);
      end else if (c != exp_cycle) begin
         failures++;
         $display("FAIL %s latency got=%0d expected=%0d", name, c, exp_cycle);
      end
      checks++;
      if (q_size(inst) != 0) begin
         failures++;
         $display("FAIL %s writes_missing got=%0d expected=0", name, q_size(inst));
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      checks++;
      if (csum_of(inst) !== exp_sum) begin
         failures++;
         $display("FAIL %s checksum got=%h expected=%h", name, csum_of(inst), exp_sum);
      end
`endif
   endtask

   task automatic check_idle_a(input string name);
      checks++;
      if ({a_mem_write, a_busy, a_load_done, a_error, a_mem_data, a_rom_address, a_state}
          !== {4'b0000, 8'h00, 32'd0, ST_IDLE}) begin
         failures++;
         $display("FAIL %s got w=%b b=%b d=%b e=%b data=%h addr=%h st=%0d expected all 0 IDLE",
                  name, a_mem_write, a_busy, a_load_done, a_error, a_mem_data,
                  a_rom_address, a_state);
      end
   endtask

   task automatic test_reset();
      #1;
      check_idle_a("reset_a");
      checks++;
      if ({m_busy, m_error, m_mem_write, b_busy, b_load_done, b_mem_write} !== 6'b0) begin
         failures++;
         $display("FAIL reset_mb got=%b expected=000000",
                  {m_busy, m_error, m_mem_write, b_busy, b_load_done, b_mem_write});
      end
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_idle_a("idle_wait");
   endtask

   task automatic test_basic();
      push_image();
      run_load(0, 1'b0, 1'b0, 108, "basic");
   endtask

   task automatic test_stall();
      push_image();
      run_load(0, 1'b1, 1'b0, 270, "stall");
   endtask

   task automatic test_back_to_back();
      push_image();
      run_load(0, 1'b0, 1'b1, 108, "back_to_back");
   endtask

   task automatic test_reset_mid_load();
      int  writes = 0;
      bit  hit = 1'b0;
      push_image();
      a_mem_ready = 1'b1;
      a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         if (a_mem_write) writes++;
         if (writes == 10) begin
            hit = 1'b1;
            break;
         end
      end
      reset_n = 1'b0;
      #1;
      check_idle_a("reset_mid");
      checks++;
      if (!hit || exp_q_a.size() != 45) begin
         failures++;
         $display("FAIL reset_mid_writes got_remaining=%0d expected=45", exp_q_a.size());
      end
      exp_q_a.delete();
      @(posedge clk); #1;
      check_idle_a("reset_hold");
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      push_image();
      run_load(0, 1'b0, 1'b0, 108, "reload");
   endtask

   task automatic test_max_error();
      for (int i = 0; i < 16; i++) exp_q_m.push_back({32'(i), 8'(i) ^ 8'h5A});
      run_load(1, 1'b0, 1'b0, 32, "max_error");
      checks++;
      if ({m_error, m_busy, m_load_done, m_mem_write} !== 4'b1000) begin
         failures++;
         $display("FAIL max_error_flags got=%b expected=1000",
                  {m_error, m_busy, m_load_done, m_mem_write});
      end
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (m_error !== 1'b1 || m_busy !== 1'b0) begin
         failures++;
         $display("FAIL max_error_hold got err=%b busy=%b expected err=1 busy=0", m_error, m_busy);
      end
   endtask

   task automatic test_single_byte();
      exp_q_b.push_back({32'h100, 8'hA5});
      run_load(2, 1'b0, 1'b0, 2, "single_byte");
   endtask

   initial begin : wd
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < 64; i++) img[i] = 8'h00;
      for (int i = 0; i < 53; i++) begin
         img[i] = (i == 0) ? 8'd34 : (i == 1) ? 8'd1 : 8'(i * 37 + 5);
         s = s + img[i];
      end
      img[53] = 8'd86 - s;

      test_reset();
      test_basic();
      test_stall();
      test_back_to_back();
      test_reset_mid_load();
      test_max_error();
      test_single_byte();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
